// File: rtl/instruction_prefetch_memory.sv
// Instruction memory with an integrated prefetch FIFO. The block owns the fetch PC,
// streams sequential words into the queue and supports redirects, faults and loads.
module instruction_prefetch_memory #(
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         ADDR_WIDTH = 32,
    parameter int unsigned         DEPTH      = 64,
    parameter int unsigned         FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_data_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_fault_o,
    output logic                  halted_o,
    input  logic                  load_en_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic [DATA_WIDTH-1:0] load_data_i
);

    localparam int unsigned MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned IW  = ADDR_WIDTH - 2;
    localparam logic [IW-1:0] DEPTH_IDX = IW'(DEPTH);
    localparam logic [PW:0]   FIFO_FULL = (PW+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DATA_WIDTH-1:0] fifo_data_q  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
    logic                  fifo_fault_q [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  halted_q, halted_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;

    logic                  pc_fault;
    logic [DATA_WIDTH-1:0] fetch_word;
    logic                  head_present;
    logic                  pop;
    logic                  issue;
    logic                  load_in_range;

    assign pc_fault   = (pc_q[1:0] != 2'b00) || (pc_q[ADDR_WIDTH-1:2] >= DEPTH_IDX);
    // The read sees the pre-edge array, so a same-cycle load of this word returns old data.
    assign fetch_word = pc_fault ? '0 : mem_q[pc_q[MAW+1:2]];

    assign head_present  = (count_q != '0);
    assign instr_valid_o = head_present && !redirect_valid_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign issue         = !halted_q && !redirect_valid_i && ((count_q != FIFO_FULL) || pop);

    assign instr_data_o  = head_present ? fifo_data_q[rd_ptr_q]  : '0;
    assign instr_addr_o  = head_present ? fifo_addr_q[rd_ptr_q]  : '0;
    assign instr_fault_o = head_present ? fifo_fault_q[rd_ptr_q] : 1'b0;
    assign halted_o      = halted_q;

    assign load_in_range = (load_addr_i[ADDR_WIDTH-1:2] < DEPTH_IDX);

    // Memory and queue payload carry no reset; the array must survive rst_n.
    always_ff @(posedge clk) begin
        if (load_en_i && load_in_range) begin
            mem_q[load_addr_i[MAW+1:2]] <= load_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            fifo_data_q[wr_ptr_q]  <= fetch_word;
            fifo_addr_q[wr_ptr_q]  <= pc_q;
            fifo_fault_q[wr_ptr_q] <= pc_fault;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid_i) begin
            pc_d     = redirect_addr_i;
            halted_d = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                pc_d     = pc_q + ADDR_WIDTH'(4);
                if (pc_fault) begin
                    halted_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({issue, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_memory.sv
// Scoreboard bench for instruction_prefetch_memory: stimulus pushes expected entries,
// a negedge monitor pops and compares every accepted head.
module tb_instruction_prefetch_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_addr;
    logic        instr_fault;
    logic        halted;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    instruction_prefetch_memory dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid_i (redirect_valid),
        .redirect_addr_i  (redirect_addr),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .instr_data_o     (instr_data),
        .instr_addr_o     (instr_addr),
        .instr_fault_o    (instr_fault),
        .halted_o         (halted),
        .load_en_i        (load_en),
        .load_addr_i      (load_addr),
        .load_data_i      (load_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int idx, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = idx * 4;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic expect_entry(input logic [31:0] a, input logic [31:0] d, input logic f);
        exp_t e;
        e.addr  = a;
        e.data  = d;
        e.fault = f;
        sb.push_back(e);
    endtask

    // Redirect held for one cycle; valid must be low in that cycle and the next.
    task automatic do_redirect(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_addr  = a;
        #1;
        check("redir_valid_n", {31'b0, instr_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("redir_valid_n1", {31'b0, instr_valid}, 32'd0);
        check("redir_halted_clr", {31'b0, halted}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got addr %h data %h, want no transfer", instr_addr, instr_data);
            end else begin
                mon_e = sb.pop_front();
                if (instr_addr !== mon_e.addr || instr_data !== mon_e.data || instr_fault !== mon_e.fault) begin
                    bad++;
                    $display("FAIL sb_entry: got %h/%h/%b want %h/%h/%b",
                             instr_addr, instr_data, instr_fault, mon_e.addr, mon_e.data, mon_e.fault);
                end
            end
        end
    end

    initial begin
        // Program memory while reset is held.
        tick();
        for (int i = 0; i < 10; i++) begin
            load_word(i, 32'h11111111 * (i + 1));
        end
        load_word(63, 32'hDEADBEEF);
        load_word(64, 32'hBAD0BAD0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_data", instr_data, 32'd0);
        check("rst_addr", instr_addr, 32'd0);
        check("rst_fault", {31'b0, instr_fault}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);

        // Initial stream with ready held high.
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_entry(i * 4, 32'h11111111 * (i + 1), 1'b0);
        end
        rst_n = 1'b1;
        #1;
        check("first_cycle_valid", {31'b0, instr_valid}, 32'd0);
        repeat (6) tick();
        instr_ready = 1'b0;
        check("stream_drained", sb.size(), 32'd0);

        // Async reset between edges, then back-pressure.
        #2;
        check("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, instr_valid}, 32'd0);
        check("async_rst_addr", instr_addr, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_head_addr", instr_addr, 32'd0);
            check("bp_head_data", instr_data, 32'h11111111);
        end
        for (int i = 0; i < 6; i++) begin
            expect_entry(i * 4, 32'h11111111 * (i + 1), 1'b0);
        end
        instr_ready = 1'b1;
        repeat (6) tick();
        instr_ready = 1'b0;
        check("bp_drained", sb.size(), 32'd0);

        // Redirect with stale entries queued; they must never be delivered.
        instr_ready = 1'b1;
        expect_entry(32'h20, 32'h99999999, 1'b0);
        expect_entry(32'h24, 32'hAAAAAAAA, 1'b0);
        do_redirect(32'h20);
        tick();
        check("redir_target_valid", {31'b0, instr_valid}, 32'd1);
        check("redir_target_addr", instr_addr, 32'h20);
        tick();
        tick();
        instr_ready = 1'b0;
        check("redir_drained", sb.size(), 32'd0);

        // Misaligned fetch faults and halts.
        do_redirect(32'h06);
        tick();
        check("mis_valid", {31'b0, instr_valid}, 32'd1);
        check("mis_addr", instr_addr, 32'h06);
        check("mis_data", instr_data, 32'd0);
        check("mis_fault", {31'b0, instr_fault}, 32'd1);
        check("mis_halted", {31'b0, halted}, 32'd1);
        expect_entry(32'h06, 32'd0, 1'b1);
        instr_ready = 1'b1;
        tick();
        check("mis_valid_after_pop", {31'b0, instr_valid}, 32'd0);
        tick();
        check("mis_still_empty", {31'b0, instr_valid}, 32'd0);
        check("mis_still_halted", {31'b0, halted}, 32'd1);

        // Last in-range word, then the out-of-range one faults.
        expect_entry(32'hFC, 32'hDEADBEEF, 1'b0);
        expect_entry(32'h100, 32'd0, 1'b1);
        do_redirect(32'hFC);
        tick();
        tick();
        check("oor_halted", {31'b0, halted}, 32'd1);
        tick();
        check("oor_valid_after", {31'b0, instr_valid}, 32'd0);
        check("oor_drained", sb.size(), 32'd0);

        // A load after an entry is queued does not change the queued copy.
        instr_ready = 1'b0;
        do_redirect(32'h0);
        tick();
        load_word(1, 32'h12345678);
        expect_entry(32'h0, 32'h11111111, 1'b0);
        expect_entry(32'h4, 32'h22222222, 1'b0);
        instr_ready = 1'b1;
        tick();
        tick();
        instr_ready = 1'b0;
        check("load_noflush_drained", sb.size(), 32'd0);

        // Reset mid-stream: queue lost, memory kept.
        #2;
        check("pre_rst2_valid", {31'b0, instr_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst2_valid", {31'b0, instr_valid}, 32'd0);
        check("rst2_data", instr_data, 32'd0);
        check("rst2_fault", {31'b0, instr_fault}, 32'd0);
        tick();
        instr_ready = 1'b1;
        expect_entry(32'h0, 32'h11111111, 1'b0);
        expect_entry(32'h4, 32'h12345678, 1'b0);
        expect_entry(32'h8, 32'h33333333, 1'b0);
        rst_n = 1'b1;
        repeat (4) tick();
        instr_ready = 1'b0;
        check("rst2_drained", sb.size(), 32'd0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch_memory.md
# instruction_prefetch_memory

Parametrised, clocked instruction memory with an integrated prefetch queue, replacing the purely combinational address-to-data instruction store. It owns the fetch PC and streams sequential words (byte-addressed, 4-byte stride) into a small FIFO. The core consumes the FIFO through a valid/ready handshake and steers fetch with a redirect port. A write port programs the memory contents.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, byte-address width
- DEPTH, 64, memory size in words (≥2)
- FIFO_DEPTH, 4, prefetch entries (power of two, ≥2)
- RESET_PC, 0, first fetch address after reset (byte address)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- redirect_valid  in  1  flush the queue and restart fetch at redirect_addr
- redirect_addr  in  ADDR_WIDTH  new fetch byte address
- instr_valid  out  1  head entry available
- instr_ready  in  1  consumer accepts head
- instr_data  out  DATA_WIDTH  head instruction word
- instr_addr  out  ADDR_WIDTH  byte address of head word
- instr_fault  out  1  head entry is a fetch fault
- halted  out  1  fetch stopped after a fault
- load_en  in  1  memory write strobe
- load_addr  in  ADDR_WIDTH  write byte address; bits [1:0] ignored
- load_data  in  DATA_WIDTH  write data

## Operation
- Word index = addr[ADDR_WIDTH-1:2].
- Fault address: addr[1:0]≠0, or word index ≥ DEPTH.
- Issue: in a cycle with !halted, !redirect_valid, and (count<FIFO_DEPTH or a pop this cycle), the block reads mem[PC] synchronously and writes {data, PC, fault} into the FIFO tail at the edge. PC advances by 4, modulo 2^ADDR_WIDTH.
- Fault entries carry data=0 and fault=1. Issuing a fault entry sets halted=1, and no further issues occur until a redirect.
- Pop: instr_valid && instr_ready. Push and pop in the same cycle at full count are allowed; count is unchanged.
- instr_valid = (count≠0) && !redirect_valid. A ready in the redirect cycle transfers nothing.
- Redirect priority is above issue and pop. At the edge the FIFO is emptied, PC←redirect_addr, halted←0, and there is no issue that cycle.
- When the FIFO is empty, instr_data, instr_addr and instr_fault read 0.
- Load: when load_en is high and the word index is < DEPTH, mem[index]←load_data at the edge. Out-of-range loads are ignored. A read of the same word in the same cycle returns the old data.
- Loads do not flush the queue. Entries already queued keep their old contents.
- Memory array is not reset. Contents survive rst_n.

## Timing
- Reset (async assert) forces instr_valid=0, instr_data=0, instr_addr=0, instr_fault=0, halted=0, count=0, PC=RESET_PC.
- First issue is in the first cycle after rst_n deasserts. instr_valid is high the following cycle.
- Fetch latency is 1 cycle from issue to head-visible when the FIFO is empty.
- With instr_ready held at 1, one instruction per cycle is delivered with no bubbles.
- Redirect asserted in cycle N: instr_valid is low in N and N+1. The target is issued in N+1 and is valid in N+2.
- Back-pressure: the head and all outputs hold stable while valid && !ready. Issue stops at count==FIFO_DEPTH unless a pop occurs.
- Reset mid-operation: all queued entries and the PC are lost. Memory is retained.

## Test plan
- Initial stream: load words 0..4 = 0x11111111×(i+1), release reset, ready=1 -> valid from cycle 1 with addr/data pairs 0/0x11111111, 4/0x22222222, 8/…, 12/…, 16/0x55555555 on consecutive cycles.
- Back-pressure: ready=0 for 10 cycles after reset -> count saturates at 4; head stays addr 0; PC stops at 16. Ready=1 -> addresses 0,4,8,12,16,20 delivered without gap or duplicate.
- Redirect: while the queue holds 0,4, pulse redirect to 0x20 in cycle N -> valid=0 in N and N+1; cycle N+2 gives addr 0x20; entries 0,4 are never delivered.
- Faults (DEPTH=64): redirect to 0x06 -> one entry with fault=1, data=0; halted=1; valid drops after pop. Redirect to 0xFC -> 0xFC delivered normally; 0x100 delivered with fault=1; halted=1.
- Full-queue push+pop: hold count=4, then ready=1 for one cycle -> head advances by 4, count stays 4, and the next PC is issued in that same cycle.
- Async reset mid-stream: drop rst_n between edges -> valid=0 immediately. After release, the stream restarts at RESET_PC with the previously loaded data.
